writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_if.sv | 44 ++++
 rtl/writeback_stage.sv | 113 +++++++++++
 tb/tb_writeback_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - pipeline-to-writeback bundle with master/slave views
interface writeback_stage_if;
  logic        register_write_writeback;
  logic        memory_to_register_writeback;
  logic        HI_register_write_writeback;
  logic        LO_register_write_writeback;
  logic        HALT_writeback;
  logic [5:0]  op_writeback;
  logic [3:0]  byteenable_writeback;
  logic [31:0] read_data_writeback;
  logic [31:0] rt_value_writeback;
  logic [31:0] ALU_output_writeback;
  logic [4:0]  write_register_writeback;
  logic [31:0] ALU_HI_output_writeback;
  logic [31:0] ALU_LO_output_writeback;
  logic        register_write_enable;
  logic [4:0]  write_register_address;
  logic [31:0] result_writeback;
  logic [31:0] HI_register_value;
  logic [31:0] LO_register_value;
  logic        halted;

  modport master (
    output register_write_writeback, memory_to_register_writeback,
           HI_register_write_writeback, LO_register_write_writeback,
           HALT_writeback, op_writeback, byteenable_writeback,
           read_data_writeback, rt_value_writeback, ALU_output_writeback,
           write_register_writeback, ALU_HI_output_writeback,
           ALU_LO_output_writeback,
    input  register_write_enable, write_register_address, result_writeback,
           HI_register_value, LO_register_value, halted
  );

  modport slave (
    input  register_write_writeback, memory_to_register_writeback,
           HI_register_write_writeback, LO_register_write_writeback,
           HALT_writeback, op_writeback, byteenable_writeback,
           read_data_writeback, rt_value_writeback, ALU_output_writeback,
           write_register_writeback, ALU_HI_output_writeback,
           ALU_LO_output_writeback,
    output register_write_enable, write_register_address, result_writeback,
           HI_register_value, LO_register_value, halted
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback: load extraction, GPR strobe, HI/LO, halt FSM (WRITEBACK_UNALIGNED_LOAD_EN enables LWL/LWR merge)
module writeback_stage (
  input logic           clk,
  input logic           reset,
  writeback_stage_if.slave wb
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q;
  logic        halted_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        run_active;
  logic [1:0]  lo_lane;
  logic [31:0] rd_shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
`ifdef WRITEBACK_UNALIGNED_LOAD_EN
  logic [1:0]  hi_lane;
`endif

  // Writes are only honoured while running and not being reset
  assign run_active = (state_q == RUN) && !reset;

  assign wb.register_write_enable  = run_active && wb.register_write_writeback &&
                                     (wb.write_register_writeback != 5'd0);
  assign wb.write_register_address = wb.write_register_writeback;
  assign wb.HI_register_value      = hi_q;
  assign wb.LO_register_value      = lo_q;
  assign wb.halted                 = halted_q;

  // Locate active byte lanes and pull the addressed byte/halfword from the memory word
  always_comb begin
    lo_lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (wb.byteenable_writeback[k]) lo_lane = 2'(k);
    end
`ifdef WRITEBACK_UNALIGNED_LOAD_EN
    hi_lane = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (wb.byteenable_writeback[k]) hi_lane = 2'(k);
    end
`endif
    rd_shifted = wb.read_data_writeback >> {lo_lane, 3'b000};
    sel_byte   = rd_shifted[7:0];
    sel_half   = (wb.byteenable_writeback == 4'b1100) ? wb.read_data_writeback[31:16]
                                                      : wb.read_data_writeback[15:0];
  end

  // Format the load by opcode; unknown opcodes load the whole word
  always_comb begin
    load_result = wb.read_data_writeback;
    case (wb.op_writeback)
      6'h20:   load_result = {{24{sel_byte[7]}}, sel_byte};
      6'h24:   load_result = {24'd0, sel_byte};
      6'h21:   load_result = {{16{sel_half[15]}}, sel_half};
      6'h25:   load_result = {16'd0, sel_half};
`ifdef WRITEBACK_UNALIGNED_LOAD_EN
      // LWL: memory bytes up to the highest lane fill the top of the register
      6'h22: begin
        case (hi_lane)
          2'd0:    load_result = {wb.read_data_writeback[7:0],  wb.rt_value_writeback[23:0]};
          2'd1:    load_result = {wb.read_data_writeback[15:0], wb.rt_value_writeback[15:0]};
          2'd2:    load_result = {wb.read_data_writeback[23:0], wb.rt_value_writeback[7:0]};
          default: load_result = wb.read_data_writeback;
        endcase
      end
      // LWR: memory bytes from the lowest lane fill the bottom of the register
      6'h26: begin
        case (lo_lane)
          2'd0:    load_result = wb.read_data_writeback;
          2'd1:    load_result = {wb.rt_value_writeback[31:24], wb.read_data_writeback[31:8]};
          2'd2:    load_result = {wb.rt_value_writeback[31:16], wb.read_data_writeback[31:16]};
          default: load_result = {wb.rt_value_writeback[31:8],  wb.read_data_writeback[31:24]};
        endcase
      end
`endif
      default: load_result = wb.read_data_writeback;
    endcase
  end

  assign wb.result_writeback = wb.memory_to_register_writeback ? load_result
                                                               : wb.ALU_output_writeback;

  // Halt FSM plus HI/LO commit; the halting instruction still commits its own writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (wb.HI_register_write_writeback) hi_q <= wb.ALU_HI_output_writeback;
          if (wb.LO_register_write_writeback) lo_q <= wb.ALU_LO_output_writeback;
          if (wb.HALT_writeback) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage with directed vectors
module tb_writeback_stage;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        halted;
  } exp_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  writeback_stage_if wb();

  writeback_stage dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation, compare at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".we"},     32'(wb.register_write_enable),  32'(e.we));
      chk({e.name, ".addr"},   32'(wb.write_register_address), 32'(e.addr));
      chk({e.name, ".result"}, wb.result_writeback,            e.res);
      chk({e.name, ".hi"},     wb.HI_register_value,           e.hi);
      chk({e.name, ".lo"},     wb.LO_register_value,           e.lo);
      chk({e.name, ".halted"}, 32'(wb.halted),                 32'(e.halted));
    end
  end

  task automatic idle_inputs();
    wb.register_write_writeback     = 1'b0;
    wb.memory_to_register_writeback = 1'b0;
    wb.HI_register_write_writeback  = 1'b0;
    wb.LO_register_write_writeback  = 1'b0;
    wb.HALT_writeback               = 1'b0;
    wb.op_writeback                 = 6'h00;
    wb.byteenable_writeback         = 4'b0000;
    wb.read_data_writeback          = 32'd0;
    wb.rt_value_writeback           = 32'd0;
    wb.ALU_output_writeback         = 32'd0;
    wb.write_register_writeback     = 5'd0;
    wb.ALU_HI_output_writeback      = 32'd0;
    wb.ALU_LO_output_writeback      = 32'd0;
  endtask

  // Start a new cycle just after the rising edge with quiet inputs
  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic expect_out(input string name, input logic we, input logic [4:0] addr,
                            input logic [31:0] res, input logic [31:0] hi,
                            input logic [31:0] lo, input logic halted);
    exp_t e;
    e.name = name; e.we = we; e.addr = addr; e.res = res;
    e.hi = hi; e.lo = lo; e.halted = halted;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [5:0] op, input logic [3:0] be, input logic [31:0] rd,
                      input logic [31:0] rt);
    wb.register_write_writeback     = 1'b1;
    wb.memory_to_register_writeback = 1'b1;
    wb.write_register_writeback     = 5'd2;
    wb.op_writeback                 = op;
    wb.byteenable_writeback         = be;
    wb.read_data_writeback          = rd;
    wb.rt_value_writeback           = rt;
    wb.ALU_output_writeback         = 32'h0BAD0BAD;
  endtask

  initial begin
    int budget;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset with a HI write pending: reset wins, strobe gated
    reset = 1'b1;
    idle_inputs();
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd5;
    wb.ALU_output_writeback = 32'h00001234;
    wb.HI_register_write_writeback = 1'b1; wb.ALU_HI_output_writeback = 32'h0000DEAD;
    expect_out("reset_gate", 1'b0, 5'd5, 32'h00001234, 32'd0, 32'd0, 1'b0);

    next_cycle();
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd5;
    wb.ALU_output_writeback = 32'hCAFEF00D;
    expect_out("alu_write", 1'b1, 5'd5, 32'hCAFEF00D, 32'd0, 32'd0, 1'b0);

    next_cycle();
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd0;
    wb.ALU_output_writeback = 32'h00000001;
    expect_out("r0_write", 1'b0, 5'd0, 32'h00000001, 32'd0, 32'd0, 1'b0);

    next_cycle(); load(6'h20, 4'b0100, 32'h00800000, 32'd0);
    expect_out("lb", 1'b1, 5'd2, 32'hFFFFFF80, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h24, 4'b0100, 32'h00800000, 32'd0);
    expect_out("lbu", 1'b1, 5'd2, 32'h00000080, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h21, 4'b1100, 32'h80017FFF, 32'd0);
    expect_out("lh_hi", 1'b1, 5'd2, 32'hFFFF8001, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h25, 4'b0011, 32'h8001F00F, 32'd0);
    expect_out("lhu_lo", 1'b1, 5'd2, 32'h0000F00F, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h23, 4'b1111, 32'hAABBCCDD, 32'd0);
    expect_out("lw", 1'b1, 5'd2, 32'hAABBCCDD, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h3F, 4'b0001, 32'h12345678, 32'd0);
    expect_out("other_op", 1'b1, 5'd2, 32'h12345678, 32'd0, 32'd0, 1'b0);

`ifdef WRITEBACK_UNALIGNED_LOAD_EN
    next_cycle(); load(6'h22, 4'b0011, 32'hAABBCCDD, 32'h11223344);
    expect_out("lwl", 1'b1, 5'd2, 32'hCCDD3344, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h26, 4'b1100, 32'hAABBCCDD, 32'h11223344);
    expect_out("lwr", 1'b1, 5'd2, 32'h1122AABB, 32'd0, 32'd0, 1'b0);
`else
    next_cycle(); load(6'h22, 4'b0011, 32'hAABBCCDD, 32'h11223344);
    expect_out("lwl_off", 1'b1, 5'd2, 32'hAABBCCDD, 32'd0, 32'd0, 1'b0);
    next_cycle(); load(6'h26, 4'b1100, 32'hAABBCCDD, 32'h11223344);
    expect_out("lwr_off", 1'b1, 5'd2, 32'hAABBCCDD, 32'd0, 32'd0, 1'b0);
`endif

    // HI and LO written together, visible one cycle later
    next_cycle();
    wb.HI_register_write_writeback = 1'b1; wb.ALU_HI_output_writeback = 32'h5;
    wb.LO_register_write_writeback = 1'b1; wb.ALU_LO_output_writeback = 32'h7;
    expect_out("hilo_issue", 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    next_cycle();
    expect_out("hilo_seen", 1'b0, 5'd0, 32'd0, 32'h5, 32'h7, 1'b0);

    // HALT with r3 write and HI write: all commit
    next_cycle();
    wb.HALT_writeback = 1'b1;
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd3;
    wb.ALU_output_writeback = 32'h33333333;
    wb.HI_register_write_writeback = 1'b1; wb.ALU_HI_output_writeback = 32'h9;
    expect_out("halt_r3", 1'b1, 5'd3, 32'h33333333, 32'h5, 32'h7, 1'b0);

    next_cycle();
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd4;
    wb.ALU_output_writeback = 32'h44444444;
    wb.HI_register_write_writeback = 1'b1; wb.ALU_HI_output_writeback = 32'hBAD;
    wb.LO_register_write_writeback = 1'b1; wb.ALU_LO_output_writeback = 32'hBAD;
    expect_out("halted_r4", 1'b0, 5'd4, 32'h44444444, 32'h9, 32'h7, 1'b1);

    next_cycle();
    expect_out("halted_hold", 1'b0, 5'd0, 32'd0, 32'h9, 32'h7, 1'b1);

    next_cycle();
    reset = 1'b1;
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd4;
    expect_out("reset_halted", 1'b0, 5'd4, 32'd0, 32'h9, 32'h7, 1'b1);

    next_cycle();
    expect_out("post_reset", 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    next_cycle();
    wb.register_write_writeback = 1'b1; wb.write_register_writeback = 5'd4;
    wb.ALU_output_writeback = 32'h00000004;
    expect_out("run_again", 1'b1, 5'd4, 32'h00000004, 32'd0, 32'd0, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
